// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: FSM states, SPI mode constants and byte width.
package spi_master_pkg;

  localparam int   BYTE_W = 8;
  localparam logic CPOL   = 1'b0;  // sclk idles low
  localparam logic CPHA   = 1'b0;  // sample on the leading (rising) edge

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SCLK_LO = 3'd2,
    ST_SCLK_HI = 3'd3,
    ST_HOLD    = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  function automatic logic [3:0] clamp_count(input logic [3:0] n, input int max_bytes);
    if (int'(n) > max_bytes) return 4'(max_bytes);
    return n;
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period counter: phase_end pulses on the CLK_DIV-th enabled cycle of each phase.
module spi_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_b,
  input  logic en,
  output logic phase_end
);

  localparam int DW = $clog2(CLK_DIV) + 1;

  logic [DW-1:0] div_cnt;

  assign phase_end = en && (div_cnt == DW'(CLK_DIV - 1));

  // Dropping enable clears the count so every phase starts from zero.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      div_cnt <= '0;
    end else if (!en || phase_end) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0, MSB first: one cs_b-framed transaction of 1..MAX_BYTES bytes.
// tx handshake: a byte transfers on any rising clk edge with tx_valid && tx_ready;
// tx_ready depends only on state (high in LOAD), never on tx_valid.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic [3:0]        nbytes,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              done,
  output logic              cs_b,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [2:0]        state_dbg
);

  state_t            state;
  logic [BYTE_W-2:0] shift_tx;  // bits still to send after the one on mosi
  logic [BYTE_W-1:0] shift_rx;
  logic [2:0]        bit_cnt;
  logic [3:0]        byte_cnt;
  logic [3:0]        nbytes_lat;
  logic              div_en;
  logic              phase_end;

  assign div_en    = state inside {ST_SCLK_LO, ST_SCLK_HI, ST_HOLD, ST_GAP};
  assign tx_ready  = (state == ST_LOAD);
  assign state_dbg = state;

  spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk       (clk),
    .rst_b     (rst_b),
    .en        (div_en),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= ST_IDLE;
      cs_b       <= 1'b1;
      sclk       <= CPOL;
      mosi       <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      shift_tx   <= '0;
      shift_rx   <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      nbytes_lat <= '0;
    end else begin
      rx_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && nbytes != 4'd0) begin
            nbytes_lat <= clamp_count(nbytes, MAX_BYTES);
            byte_cnt   <= '0;
            cs_b       <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          sclk <= CPOL;
          if (tx_valid) begin
            mosi     <= tx_data[BYTE_W-1];
            shift_tx <= tx_data[BYTE_W-2:0];
            bit_cnt  <= '0;
            state    <= ST_SCLK_LO;
          end
        end
        ST_SCLK_LO: begin
          if (phase_end) begin
            sclk <= ~CPOL;
            if (!CPHA) shift_rx <= {shift_rx[BYTE_W-2:0], miso};
            state <= ST_SCLK_HI;
          end
        end
        ST_SCLK_HI: begin
          if (phase_end) begin
            sclk <= CPOL;
            if (bit_cnt != 3'(BYTE_W - 1)) begin
              mosi     <= shift_tx[BYTE_W-2];
              shift_tx <= {shift_tx[BYTE_W-3:0], 1'b0};
              bit_cnt  <= bit_cnt + 3'd1;
              state    <= ST_SCLK_LO;
            end else begin
              rx_data  <= shift_rx;
              rx_valid <= 1'b1;
              byte_cnt <= byte_cnt + 4'd1;
              state    <= (byte_cnt + 4'd1 >= nbytes_lat) ? ST_HOLD : ST_LOAD;
            end
          end
        end
        ST_HOLD: begin
          if (phase_end) begin
            cs_b  <= 1'b1;
            done  <= 1'b1;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (phase_end) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master with a behavioural SPI slave and byte-level scoreboard.
module tb_spi_master;

  localparam int CLK_DIV   = 2;
  localparam int MAX_BYTES = 8;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       start = 1'b0;
  logic [3:0] nbytes = '0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       miso = 1'b0;
  logic       tx_ready, rx_valid, busy, done, cs_b, sclk, mosi;
  logic [7:0] rx_data;
  logic [2:0] state_dbg;

  spi_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .nbytes    (nbytes),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .done      (done),
    .cs_b      (cs_b),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- slave model + monitor ----------------
  logic [7:0] slv_mem [16];
  logic [7:0] exp_q [$];       // expected rx bytes
  logic [7:0] exp_mosi_q [$];  // expected bytes on mosi
  logic [7:0] cap = '0;
  int cap_n = 0, slv_pos = 0;
  logic prev_sclk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0;
  int rx_cnt, done_cnt, rise_cnt, mosi_err, cs_glitch;
  int ev_cs_lo, ev_sclk1, ev_sclk2, ev_rx, ev_done, ev_busy_lo;
  int t0 = 0;
  bit armed = 0;

  function automatic logic slv_bit(input int p);
    if (p >= 128) return 1'b0;
    return slv_mem[p / 8][7 - (p % 8)];
  endfunction

  task automatic arm();
    t0 = cyc;
    ev_cs_lo = -1; ev_sclk1 = -1; ev_sclk2 = -1;
    ev_rx = -1; ev_done = -1; ev_busy_lo = -1;
    rx_cnt = 0; done_cnt = 0; rise_cnt = 0; mosi_err = 0; cs_glitch = 0;
    armed = 1;
  endtask

  always @(negedge clk) begin
    int idx;
    idx = cyc - t0;
    if (prev_cs && !cs_b) begin
      slv_pos = 0;
      cap_n   = 0;
      miso    = slv_bit(0);
    end else if (!cs_b) begin
      if (!prev_sclk && sclk) begin
        cap = {cap[6:0], mosi};
        cap_n++;
        slv_pos++;
        rise_cnt++;
        if (armed && rise_cnt == 1) ev_sclk1 = idx;
        if (armed && rise_cnt == 2) ev_sclk2 = idx;
        if (cap_n == 8) begin
          cap_n = 0;
          check("mosi_q_avail", 32'(exp_mosi_q.size() != 0), 1);
          if (exp_mosi_q.size() != 0) check("mosi_byte", cap, exp_mosi_q.pop_front());
        end
      end
      if (prev_sclk && !sclk) miso = slv_bit(slv_pos);
    end
    if (prev_sclk && sclk && mosi !== prev_mosi) mosi_err++;
    if (rx_valid) begin
      rx_cnt++;
      check("rx_q_avail", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("rx_data", rx_data, exp_q.pop_front());
    end
    if (done) done_cnt++;
    if (armed) begin
      if (!cs_b && ev_cs_lo < 0) ev_cs_lo = idx;
      if (rx_valid && ev_rx < 0) ev_rx = idx;
      if (done && ev_done < 0) ev_done = idx;
      if (!busy && ev_busy_lo < 0 && ev_cs_lo >= 0) ev_busy_lo = idx;
      if (cs_b && ev_cs_lo >= 0 && ev_done < 0) cs_glitch++;
    end
    prev_sclk = sclk;
    prev_cs   = cs_b;
    prev_mosi = mosi;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int t = 0; t < 2000; t++) begin
      if (tx_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_txn(input int nb_req, input int stall_idx, input int stall_len,
                         input bit extra_start);
    int n;
    int t;
    int hold_bad;
    int idle_bad;
    bit ok;
    logic [7:0] txb [16];
    n = (nb_req > MAX_BYTES) ? MAX_BYTES : nb_req;
    exp_q.delete();
    exp_mosi_q.delete();
    for (int i = 0; i < 16; i++) begin
      txb[i]     = 8'($urandom_range(0, 255));
      slv_mem[i] = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(slv_mem[i]);
      exp_mosi_q.push_back(txb[i]);
    end
    @(negedge clk);
    arm();
    nbytes   = 4'(nb_req);
    tx_data  = txb[0];
    tx_valid = (stall_idx != 0);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          tx_data = txb[i];
          if (i == stall_idx) begin
            tx_valid = 1'b0;
            wait_ready(ok);
            hold_bad = 0;
            repeat (stall_len) begin
              @(negedge clk);
              if (sclk || cs_b || !tx_ready) hold_bad++;
            end
            check("stall_hold", hold_bad, 0);
          end
          tx_valid = 1'b1;
          wait_ready(ok);
          if (!ok) begin
            check("tx_ready_timeout", 0, 1);
            break;
          end
          @(posedge clk);
          #1;
        end
        tx_valid = 1'b0;
      end
      begin
        if (extra_start) begin
          repeat (30) @(negedge clk);
          check("busy_at_extra_start", busy, 1);
          nbytes = 4'd3;
          start  = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    join
    t = 0;
    while (busy && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("busy_clear", busy, 0);
    idle_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || !cs_b) idle_bad++;
    end
    check("idle_after", idle_bad, 0);
    check("done_cnt", done_cnt, 1);
    check("rx_cnt", rx_cnt, n);
    check("sclk_rises", rise_cnt, 8 * n);
    check("mosi_stable", mosi_err, 0);
    check("cs_low_frame", cs_glitch, 0);
    check("rx_q_empty", exp_q.size(), 0);
    check("mosi_q_empty", exp_mosi_q.size(), 0);
    armed = 0;
  endtask

  task automatic abort_test();
    logic [7:0] b;
    int t;
    b = 8'($urandom_range(0, 255));
    for (int i = 0; i < 16; i++) slv_mem[i] = 8'($urandom_range(0, 255));
    exp_q.delete();
    exp_mosi_q.delete();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(slv_mem[i]);
      exp_mosi_q.push_back(b);
    end
    @(negedge clk);
    arm();
    nbytes   = 4'd4;
    tx_data  = b;
    tx_valid = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (rx_cnt < 2 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("abort_reach_byte3", rx_cnt, 2);
    repeat (3 * CLK_DIV) @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("abort_cs_b", cs_b, 1);
    check("abort_sclk", sclk, 0);
    check("abort_mosi", mosi, 0);
    check("abort_busy", busy, 0);
    check("abort_tx_ready", tx_ready, 0);
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_rx_data", rx_data, 0);
    exp_mosi_q.delete();
    exp_q.delete();
    armed = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int zero_bad;
    int si;
    repeat (3) @(negedge clk);
    check("rst_cs_b", cs_b, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_data", rx_data, 0);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // single-byte frame with tx_valid held high: exact cycle positions
    run_txn(1, -1, 0, 0);
    check("t_cs_lo", ev_cs_lo, 1);
    check("t_sclk_rise1", ev_sclk1, 4);
    check("t_sclk_period", ev_sclk2 - ev_sclk1, 4);
    check("t_rx_valid", ev_rx, 34);
    check("t_done", ev_done, 36);
    check("t_busy_lo", ev_busy_lo, 38);

    run_txn(8, -1, 0, 0);
    run_txn(8, -1, 0, 0);
    run_txn(3, 1, 20, 0);

    abort_test();
    run_txn(2, -1, 0, 0);

    @(negedge clk);
    arm();
    nbytes = 4'd0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    zero_bad = 0;
    repeat (10) begin
      if (busy || !cs_b) zero_bad++;
      @(negedge clk);
    end
    check("zero_ignored", zero_bad, 0);
    check("zero_no_done", done_cnt, 0);
    armed = 0;

    run_txn(8, -1, 0, 1);
    run_txn(12, -1, 0, 0);

    for (int k = 0; k < 6; k++) begin
      si = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1;
      run_txn(int'($urandom_range(1, 15)), si, int'($urandom_range(1, 10)), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
